answer_check: RTL

ANSWER_CHECK -- requirements
Module: answer_check

---
 rtl/answer_check.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/answer_check.sv
// answer_check: answer-window controller for the symbol-counting game.
//   After a game period ends (answerSig), the player adjusts a guess with
//   btnUp/btnDown and submits it before ANSWER_TIME seconds expire. The verdict
//   is shown for SHOW_TIME seconds, then nextGame requests the next period.
// Ports:
//   Clk100M        sole clock, rising edge
//   Reset          synchronous, active-high
//   tick1Hz        one-cycle pulse per second
//   answerSig      game period ended; numSpecial valid this cycle
//   numSpecial[8]  correct answer for the round
//   btnUp/btnDown/btnSubmit  debounced one-cycle button pulses
//   guess[8]       player's current count
//   answerOpen     answer window open
//   timeLeft[8]    seconds left in the window, 0 outside it
//   resultValid    one-cycle verdict strobe
//   resultCorrect  latest verdict, held until the next one
//   score[8]       correct rounds since reset, saturating
//   nextGame       one-cycle request for the next game period
module answer_check #(
  parameter int ANSWER_TIME = 10,
  parameter int SHOW_TIME   = 3
) (
  input  logic       Clk100M,
  input  logic       Reset,
  input  logic       tick1Hz,
  input  logic       answerSig,
  input  logic [7:0] numSpecial,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnSubmit,
  output logic [7:0] guess,
  output logic       answerOpen,
  output logic [7:0] timeLeft,
  output logic       resultValid,
  output logic       resultCorrect,
  output logic [7:0] score,
  output logic       nextGame
);

  localparam logic [7:0] LP_AT    = 8'(ANSWER_TIME);
  localparam logic [7:0] LP_AT_M1 = 8'(ANSWER_TIME - 1);
  localparam logic [7:0] LP_SH_M1 = 8'(SHOW_TIME - 1);

  typedef enum logic [1:0] {IDLE, ANSWER, RESULT} state_t;

  state_t     r_state;
  logic [7:0] r_target;
  logic [7:0] r_timer;
  logic [7:0] r_guess;
  logic       r_open;
  logic [7:0] r_time_left;
  logic       r_valid;
  logic       r_correct;
  logic [7:0] r_score;
  logic       r_next;

  logic [7:0] w_guess_step;
  logic       w_timeout;
  logic       w_verdict;
  logic       w_correct;

  // Up and down together cancel; both directions saturate.
  always_comb begin
    w_guess_step = r_guess;
    if (btnUp && !btnDown && r_guess != 8'hFF)
      w_guess_step = r_guess + 8'd1;
    else if (btnDown && !btnUp && r_guess != 8'h00)
      w_guess_step = r_guess - 8'd1;
  end

  assign w_timeout = tick1Hz && (r_timer == LP_AT_M1);
  assign w_verdict = btnSubmit || w_timeout;
  // A submit overrides a coincident timeout and compares the pre-button guess.
  assign w_correct = btnSubmit && (r_guess == r_target);

  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_target    <= 8'd0;
      r_timer     <= 8'd0;
      r_guess     <= 8'd0;
      r_open      <= 1'b0;
      r_time_left <= 8'd0;
      r_valid     <= 1'b0;
      r_correct   <= 1'b0;
      r_score     <= 8'd0;
      r_next      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_next  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (answerSig) begin
            r_target    <= numSpecial;
            r_guess     <= 8'd0;
            r_timer     <= 8'd0;
            r_open      <= 1'b1;
            r_time_left <= LP_AT;
            r_state     <= ANSWER;
          end
        end
        ANSWER: begin
          if (w_verdict) begin
            r_valid     <= 1'b1;
            r_correct   <= w_correct;
            if (w_correct && r_score != 8'hFF)
              r_score <= r_score + 8'd1;
            // Buttons coincident with a submit are discarded.
            if (!btnSubmit)
              r_guess <= w_guess_step;
            r_open      <= 1'b0;
            r_timer     <= 8'd0;
            r_time_left <= 8'd0;
            r_state     <= RESULT;
          end else begin
            r_guess <= w_guess_step;
            if (tick1Hz) begin
              r_timer     <= r_timer + 8'd1;
              r_time_left <= LP_AT - r_timer - 8'd1;
            end
          end
        end
        RESULT: begin
          if (tick1Hz) begin
            if (r_timer == LP_SH_M1) begin
              r_next  <= 1'b1;
              r_timer <= 8'd0;
              r_state <= IDLE;
            end else begin
              r_timer <= r_timer + 8'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign guess         = r_guess;
  assign answerOpen    = r_open;
  assign timeLeft      = r_time_left;
  assign resultValid   = r_valid;
  assign resultCorrect = r_correct;
  assign score         = r_score;
  assign nextGame      = r_next;

endmodule
